// File: rtl/watch_pkg.sv
// Shared WatchChip definitions: button channel indices
// and the auto-repeat FSM state encoding.
package watch_pkg;

  localparam int unsigned BTN_MODE  = 0;
  localparam int unsigned BTN_SET   = 1;
  localparam int unsigned BTN_INC   = 2;
  localparam int unsigned BTN_DEC   = 3;
  localparam int unsigned BTN_LIGHT = 4;
  localparam int unsigned N_BTN     = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop sync, debounce filter,
// press edge detect and optional auto-repeat FSM.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   btn_raw   - raw asynchronous pad level (1 = pressed)
//   btn_press - one-cycle strobe on press / repeat
//   btn_level - debounced registered level
module btn_debounce
  import watch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 655,
  parameter int unsigned REPEAT_DELAY    = 16384,
  parameter int unsigned REPEAT_RATE     = 4096,
  parameter int unsigned CNT_W           = 15,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_press,
  output logic btn_level
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic             level_q;
  logic             press_q, press_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] rp_cnt_q, rp_cnt_d;
  rpt_state_e       state_q, state_d;
  logic             edge_w;
  logic             rep_w;

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (s2_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // level_q lags stable_q by one cycle, so this
  // is exactly the cycle where level will rise.
  assign edge_w = stable_q & ~level_q;

  always_comb begin
    state_d  = state_q;
    rp_cnt_d = rp_cnt_q;
    rep_w    = 1'b0;
    if (!stable_q) begin
      // release wins over a strobe due this cycle
      state_d  = IDLE;
      rp_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (edge_w && REPEAT_EN) begin
            state_d  = DELAY;
            rp_cnt_d = '0;
          end
        end
        DELAY: begin
          if (rp_cnt_q == RD_LAST) begin
            rep_w    = 1'b1;
            rp_cnt_d = '0;
            state_d  = REPEAT;
          end else begin
            rp_cnt_d = rp_cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (rp_cnt_q == RR_LAST) begin
            rep_w    = 1'b1;
            rp_cnt_d = '0;
          end else begin
            rp_cnt_d = rp_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = IDLE;
          rp_cnt_d = '0;
        end
      endcase
    end
  end

  assign press_d = edge_w | rep_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      db_cnt_q <= '0;
      rp_cnt_q <= '0;
      state_q  <= IDLE;
    end else begin
      s1_q     <= btn_raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      level_q  <= stable_q;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
      rp_cnt_q <= rp_cnt_d;
      state_q  <= state_d;
    end
  end

  assign btn_press = press_q;
  assign btn_level = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw watch buttons for the core.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   btn_raw   - raw pad levels [N_BTN], 1 = pressed
//   btn_press - per-button press/repeat strobes
//   btn_level - per-button debounced levels
module button_conditioner #(
  parameter int unsigned       N_BTN           = watch_pkg::N_BTN,
  parameter int unsigned       DEBOUNCE_CYCLES = 655,
  parameter int unsigned       REPEAT_DELAY    = 16384,
  parameter int unsigned       REPEAT_RATE     = 4096,
  parameter logic [N_BTN-1:0]  REPEAT_MASK     = 5'b01100,
  parameter int unsigned       CNT_W           = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_level
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .CNT_W           (CNT_W),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[i]),
      .btn_press (btn_press[i]),
      .btn_level (btn_level[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner
// (DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_RATE=8).
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn_raw = '0;
  logic [4:0] btn_press;
  logic [4:0] btn_level;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN           (5),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (16),
    .REPEAT_RATE     (8),
    .REPEAT_MASK     (5'b01100),
    .CNT_W           (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_press (btn_press),
    .btn_level (btn_level)
  );

  typedef struct {
    logic [4:0] raw;
    int         n;
    logic [4:0] press;
    logic [4:0] level;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int c,
                     input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, c, act, exp);
    end
  endtask

  // drive away from the edge, clock once, sample 1 time unit later
  task automatic step(input logic [4:0] r, input logic rs);
    @(negedge clk);
    btn_raw = r;
    rst     = rs;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rng(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [127:0] bit1(input int k);
    logic [127:0] m;
    m = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  // cycle c = outputs just after the c-th edge of the run (1-based)
  task automatic run_hold(input string nm, input logic [4:0] m,
                          input int hold, input int total,
                          input int rst_at,
                          input logic [127:0] pexp,
                          input logic [127:0] lexp);
    for (int c = 1; c <= total; c++) begin
      step((c <= hold) ? m : 5'b0, c == rst_at);
      chk({nm, "_press"}, c, btn_press, pexp[c] ? m : 5'b0);
      chk({nm, "_level"}, c, btn_level, lexp[c] ? m : 5'b0);
    end
  endtask

  initial begin
    step(5'b0, 1'b1);
    step(5'b0, 1'b1);
    chk("reset_press", 0, btn_press, 5'b0);
    chk("reset_level", 0, btn_level, 5'b0);
    step(5'b0, 1'b0);
    step(5'b0, 1'b0);

    // mode held 40 cycles: strobe at 7, level 7..46
    tbl.push_back('{5'b00001, 6,  5'b00000, 5'b00000});
    tbl.push_back('{5'b00001, 1,  5'b00001, 5'b00001});
    tbl.push_back('{5'b00001, 33, 5'b00000, 5'b00001});
    tbl.push_back('{5'b00000, 6,  5'b00000, 5'b00001});
    tbl.push_back('{5'b00000, 6,  5'b00000, 5'b00000});
    // set bouncing every 2 cycles: never accepted
    for (int k = 0; k < 8; k++) begin
      tbl.push_back('{5'b00010, 2, 5'b00000, 5'b00000});
      tbl.push_back('{5'b00000, 2, 5'b00000, 5'b00000});
    end
    tbl.push_back('{5'b00000, 8, 5'b00000, 5'b00000});

    foreach (tbl[v]) begin
      for (int k = 0; k < tbl[v].n; k++) begin
        step(tbl[v].raw, 1'b0);
        chk("tbl_press", v, btn_press, tbl[v].press);
        chk("tbl_level", v, btn_level, tbl[v].level);
      end
    end

    // inc held 50: strobes 7,23,31,39,47,55
    run_hold("inc_rep", 5'b00100, 50, 65, 0,
             bit1(7) | bit1(23) | bit1(31) | bit1(39) |
             bit1(47) | bit1(55),
             rng(7, 56));

    // inc+dec together: aligned strobes 7,23,31
    run_hold("incdec", 5'b01100, 30, 45, 0,
             bit1(7) | bit1(23) | bit1(31),
             rng(7, 36));

    // light with reset mid-hold at edge 10
    run_hold("light_rst", 5'b10000, 20, 35, 10,
             bit1(7) | bit1(17),
             rng(7, 9) | rng(17, 26));

    // dec level drops one cycle before first repeat is due
    run_hold("dec_cut", 5'b01000, 15, 30, 0,
             bit1(7), rng(7, 21));
    run_hold("dec_again", 5'b01000, 30, 45, 0,
             bit1(7) | bit1(23) | bit1(31),
             rng(7, 36));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
